// File: rtl/decoder3x8_seq_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder: state encoding,
// inactive word per polarity and the code -> one-hot decode.
package decoder3x8_seq_pkg;

  typedef enum logic [1:0] {
    StDEmpty = 2'd0,
    StDFull  = 2'd1,
    StSwitch = 2'd2,
    StScan   = 2'd3
  } state_e;

  localparam logic [7:0] InactiveHigh = 8'h00;
  localparam logic [7:0] InactiveLow  = 8'hFF;

  function automatic logic [7:0] inactive_word(input bit active_low);
    return active_low ? InactiveLow : InactiveHigh;
  endfunction

  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [7:0] word;
    word = '0;
    for (int k = 0; k < 8; k++) begin
      word[k] = (code == 3'(k));
    end
    return word;
  endfunction

  function automatic logic [7:0] apply_polarity(input logic [7:0] word, input bit active_low);
    return active_low ? ~word : word;
  endfunction

endpackage

// File: rtl/decoder3x8_seq_if.sv
// Handshake/bus bundle of the 3-to-8 decoder; master drives stimulus, slave is the decoder.
interface decoder3x8_seq_if;
  logic       en;
  logic       mode;
  logic [2:0] code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] scan_code;

  modport master (
    output en, mode, code, in_valid, out_ready,
    input  in_ready, data, out_valid, scan_code
  );

  modport slave (
    input  en, mode, code, in_valid, out_ready,
    output in_ready, data, out_valid, scan_code
  );
endinterface

// File: rtl/decoder3x8_seq_scan_divider.sv
// Scan step divider: counts 0..ScanDiv-1 and advances a wrapping 3-bit scan index
// on the terminal count; synchronous clear, holds when neither clear nor step.
module decoder3x8_seq_scan_divider #(
  parameter int unsigned ScanDiv = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [2:0] idx_o,
  output logic [2:0] idx_next_o
);

  localparam logic [7:0] TermCnt = 8'(ScanDiv - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       tc;

  assign tc = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      if (tc) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o      = idx_q;
  assign idx_next_o = idx_d;

endmodule

// File: rtl/decoder3x8_seq.sv
// Registered 3-to-8 one-hot decoder with a valid/ready direct mode and a free-running
// scan mode; a one-cycle flush separates the two modes.
module decoder3x8_seq
  import decoder3x8_seq_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  decoder3x8_seq_if.slave bus
);

  localparam logic [7:0] Inactive = inactive_word(ACTIVE_LOW);

  state_e     state_q;
  logic [7:0] data_q;
  logic       out_valid_q;
  logic       mode_chg;
  logic       in_ready;
  logic       accept;
  logic       div_clr;
  logic       div_step;
  logic [2:0] scan_idx;
  logic [2:0] scan_idx_next;

  // SWITCH carries no mode of its own, so it never requests another flush.
  always_comb begin
    mode_chg = 1'b0;
    unique case (state_q)
      StDEmpty, StDFull: mode_chg = bus.mode;
      StScan:            mode_chg = ~bus.mode;
      default:           mode_chg = 1'b0;
    endcase
  end

  assign in_ready = bus.en & ~bus.mode &
                    ((state_q == StDEmpty) | ((state_q == StDFull) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign div_clr  = bus.en & (mode_chg | (state_q == StSwitch));
  assign div_step = bus.en & ~mode_chg & (state_q == StScan);

  decoder3x8_seq_scan_divider #(
    .ScanDiv(SCAN_DIV)
  ) u_scan_divider (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (div_clr),
    .step_i    (div_step),
    .idx_o     (scan_idx),
    .idx_next_o(scan_idx_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDEmpty;
      data_q      <= Inactive;
      out_valid_q <= 1'b0;
    end else if (bus.en) begin
      if (mode_chg) begin
        state_q     <= StSwitch;
        data_q      <= Inactive;
        out_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StSwitch: begin
            if (bus.mode) begin
              state_q     <= StScan;
              data_q      <= apply_polarity(decode(3'd0), ACTIVE_LOW);
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= StDEmpty;
              data_q      <= Inactive;
              out_valid_q <= 1'b0;
            end
          end
          StScan: begin
            data_q      <= apply_polarity(decode(scan_idx_next), ACTIVE_LOW);
            out_valid_q <= 1'b1;
          end
          StDEmpty: begin
            if (accept) begin
              state_q     <= StDFull;
              data_q      <= apply_polarity(decode(bus.code), ACTIVE_LOW);
              out_valid_q <= 1'b1;
            end
          end
          StDFull: begin
            if (accept) begin
              data_q <= apply_polarity(decode(bus.code), ACTIVE_LOW);
            end else if (bus.out_ready) begin
              state_q     <= StDEmpty;
              data_q      <= Inactive;
              out_valid_q <= 1'b0;
            end
          end
          default: state_q <= StDEmpty;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = bus.en & out_valid_q;
  assign bus.data      = bus.en ? data_q : Inactive;
  assign bus.scan_code = scan_idx;

endmodule
